// File: rtl/curr_cb_feeder.sv
// curr_cb_feeder
//
// Streams one current block (N_PIX pixels) from a valid/ready source into the
// PE chain and tracks which of the four current-block slots hold a complete
// block. A load targets one slot. A load is refused if that slot is already
// loaded, or if the PE array is comparing against that slot. Once a load is
// accepted it runs until all N_PIX pixels have been pushed, or until abort or
// reset stops it.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_load      request to load the slot given by slot_sel
//   slot_sel[1:0]   target slot, 0..3
//   abort           cancel the load in progress (only acts in LOAD)
//   src_pix         source pixel, with src_valid / src_ready handshake
//   cmp_active      PE array is differencing slot cmp_slot
//   cmp_slot[1:0]   slot used by the running comparison
//   slot_release    one-hot per slot; clears that slot's loaded flag
//   in_curr         pixel to the first PE; in_curr_enable is its shift-enable
//   CB_select[2:0]  PE register slot select ({0, slot of the last accepted load})
//   slot_loaded     per-slot "block fully loaded" status
//   load_busy       high while a load is in progress
//   load_done       one-cycle pulse when a load completes
//   load_err        one-cycle pulse when start_load is rejected
module curr_cb_feeder #(
    parameter int N_PIX   = 64,
    parameter int PIXEL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_load,
    input  logic [1:0]         slot_sel,
    input  logic               abort,
    input  logic [PIXEL_W-1:0] src_pix,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic               cmp_active,
    input  logic [1:0]         cmp_slot,
    input  logic [3:0]         slot_release,
    output logic [PIXEL_W-1:0] in_curr,
    output logic               in_curr_enable,
    output logic [2:0]         CB_select,
    output logic [3:0]         slot_loaded,
    output logic               load_busy,
    output logic               load_done,
    output logic               load_err
);

    localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         slot_reg, slot_next;
    logic [PIXEL_W-1:0] in_curr_reg, in_curr_next;
    logic               in_curr_enable_reg, in_curr_enable_next;
    logic               load_done_reg, load_done_next;
    logic               load_err_reg, load_err_next;
    logic [3:0]         slot_loaded_reg;
    logic [3:0]         slot_set;
    logic               xfer;

    // src_ready depends on the state only, so a transfer is simply valid in LOAD.
    assign xfer = src_valid && (state_reg == LOAD);

    always_comb begin
        state_next          = state_reg;
        cnt_next            = cnt_reg;
        slot_next           = slot_reg;
        in_curr_next        = in_curr_reg;
        in_curr_enable_next = 1'b0;
        load_done_next      = 1'b0;
        load_err_next       = 1'b0;

        // A transfer is pushed even in the cycle where abort ends the load.
        if (xfer) begin
            in_curr_next        = src_pix;
            in_curr_enable_next = 1'b1;
            cnt_next            = cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start_load) begin
                    if (slot_loaded_reg[slot_sel] || (cmp_active && (cmp_slot == slot_sel))) begin
                        load_err_next = 1'b1;
                    end else begin
                        slot_next  = slot_sel;
                        cnt_next   = '0;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer && (cnt_reg == CNT_LAST)) begin
                    state_next     = DONE;
                    load_done_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            cnt_reg            <= '0;
            slot_reg           <= '0;
            in_curr_reg        <= '0;
            in_curr_enable_reg <= 1'b0;
            load_done_reg      <= 1'b0;
            load_err_reg       <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cnt_reg            <= cnt_next;
            slot_reg           <= slot_next;
            in_curr_reg        <= in_curr_next;
            in_curr_enable_reg <= in_curr_enable_next;
            load_done_reg      <= load_done_next;
            load_err_reg       <= load_err_next;
        end
    end

    // Per-slot loaded flags. The flag is set while in DONE, and a release in
    // the same cycle loses to the set.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_set[gi] = (state_reg == DONE) && (slot_reg == 2'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_loaded_reg[gi] <= 1'b0;
                end else begin
                    slot_loaded_reg[gi] <= slot_set[gi] | (slot_loaded_reg[gi] & ~slot_release[gi]);
                end
            end
        end
    endgenerate

    assign src_ready      = (state_reg == LOAD);
    assign load_busy      = (state_reg == LOAD);
    assign in_curr        = in_curr_reg;
    assign in_curr_enable = in_curr_enable_reg;
    assign CB_select      = {1'b0, slot_reg};
    assign slot_loaded    = slot_loaded_reg;
    assign load_done      = load_done_reg;
    assign load_err       = load_err_reg;

endmodule

// File: tb/tb_curr_cb_feeder.sv
// Testbench for curr_cb_feeder. The reference model works at the transaction
// level: it tracks the expected loaded-slot set, the expected CB_select and the
// last pixel pushed. Each load is followed transfer by transfer.
module tb_curr_cb_feeder;

    localparam int N_PIX   = 64;
    localparam int PIXEL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_load = 1'b0;
    logic [1:0]         slot_sel = 2'd0;
    logic               abort = 1'b0;
    logic [PIXEL_W-1:0] src_pix = '0;
    logic               src_valid = 1'b0;
    logic               src_ready;
    logic               cmp_active = 1'b0;
    logic [1:0]         cmp_slot = 2'd0;
    logic [3:0]         slot_release = 4'd0;
    logic [PIXEL_W-1:0] in_curr;
    logic               in_curr_enable;
    logic [2:0]         CB_select;
    logic [3:0]         slot_loaded;
    logic               load_busy;
    logic               load_done;
    logic               load_err;

    curr_cb_feeder #(
        .N_PIX   (N_PIX),
        .PIXEL_W (PIXEL_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_load     (start_load),
        .slot_sel       (slot_sel),
        .abort          (abort),
        .src_pix        (src_pix),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .cmp_active     (cmp_active),
        .cmp_slot       (cmp_slot),
        .slot_release   (slot_release),
        .in_curr        (in_curr),
        .in_curr_enable (in_curr_enable),
        .CB_select      (CB_select),
        .slot_loaded    (slot_loaded),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .load_err       (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0]         exp_loaded = 4'd0;
    logic [2:0]         exp_cb     = 3'd0;
    logic [PIXEL_W-1:0] last_pix   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_load   = 1'b0;
        abort        = 1'b0;
        src_valid    = 1'b0;
        cmp_active   = 1'b0;
        slot_release = 4'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_curr"},   32'(in_curr),        32'd0);
        chk({tag, "_enable"},    32'(in_curr_enable), 32'd0);
        chk({tag, "_cb_select"}, 32'(CB_select),      32'd0);
        chk({tag, "_loaded"},    32'(slot_loaded),    32'd0);
        chk({tag, "_done"},      32'(load_done),      32'd0);
        chk({tag, "_err"},       32'(load_err),       32'd0);
        chk({tag, "_ready"},     32'(src_ready),      32'd0);
        chk({tag, "_busy"},      32'(load_busy),      32'd0);
    endtask

    // A start_load that must be refused.
    task automatic try_reject(input logic [1:0] slot, input logic ca, input logic [1:0] cs);
        start_load = 1'b1;
        slot_sel   = slot;
        cmp_active = ca;
        cmp_slot   = cs;
        tick();
        clear_inputs();
        chk("rej_err_pulse", 32'(load_err),  32'd1);
        chk("rej_ready",     32'(src_ready), 32'd0);
        chk("rej_busy",      32'(load_busy), 32'd0);
        chk("rej_cb_hold",   32'(CB_select), 32'(exp_cb));
        tick();
        chk("rej_err_clear", 32'(load_err),  32'd0);
        chk("rej_ready2",    32'(src_ready), 32'd0);
        chk("rej_loaded",    32'(slot_loaded), 32'(exp_loaded));
        $display("reject slot %0d cmp_active %0d cmp_slot %0d: load_err %0d", slot, ca, cs, load_err);
    endtask

    task automatic do_release(input logic [3:0] mask);
        slot_release = mask;
        tick();
        clear_inputs();
        exp_loaded = exp_loaded & ~mask;
        chk("release_loaded", 32'(slot_loaded), 32'(exp_loaded));
        $display("release mask %b: slot_loaded %b", mask, slot_loaded);
    endtask

    // mode 0: src_valid held high with pixels 1..N_PIX
    // mode 1: src_valid alternates 1,0
    // mode 2: src_valid random (~60%), random pixels
    // abort_at / reset_at: number of completed transfers at which to act (-1 = never)
    task automatic run_load(input logic [1:0] slot, input int mode, input int abort_at,
                            input int reset_at, input logic [3:0] rel_done);
        int                 n = 0;
        int                 cycles = 0;
        logic               v;
        logic               ab;
        logic [PIXEL_W-1:0] pix;
        bit                 aborted = 0;

        // Start cycle: abort in IDLE must not matter; comparison is on another slot.
        start_load = 1'b1;
        slot_sel   = slot;
        abort      = 1'($urandom_range(0, 1));
        cmp_active = 1'($urandom_range(0, 1));
        cmp_slot   = slot + 2'd1;
        tick();
        clear_inputs();
        exp_cb = {1'b0, slot};
        chk("start_busy",   32'(load_busy), 32'd1);
        chk("start_cb",     32'(CB_select), 32'(exp_cb));
        chk("start_no_err", 32'(load_err),  32'd0);

        while (n < N_PIX && cycles < 1000) begin
            cycles++;
            chk("load_ready", 32'(src_ready), 32'd1);
            if (n == reset_at) begin
                rst_n = 1'b0;
                #2;
                chk_all_zero("async_rst");
                rst_n      = 1'b1;
                exp_loaded = 4'd0;
                exp_cb     = 3'd0;
                last_pix   = '0;
                $display("load slot %0d interrupted by reset after %0d transfers", slot, n);
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2) == 1;
                default: v = ($urandom_range(0, 99) < 60);
            endcase
            ab = (n == abort_at);
            if (ab) v = 1'b1;
            pix = (mode == 0) ? PIXEL_W'(n + 1) : PIXEL_W'($urandom);
            src_valid  = v;
            src_pix    = pix;
            abort      = ab;
            start_load = 1'($urandom_range(0, 1));
            slot_sel   = 2'($urandom);
            cmp_active = 1'($urandom);
            cmp_slot   = 2'($urandom);
            tick();
            clear_inputs();
            chk("push_enable", 32'(in_curr_enable), 32'(v));
            if (v) begin
                last_pix = pix;
                n++;
            end
            chk("push_pixel", 32'(in_curr), 32'(last_pix));
            chk("load_no_err", 32'(load_err), 32'd0);
            chk("load_cb", 32'(CB_select), 32'(exp_cb));
            if (ab) begin
                aborted = 1;
                chk("abort_busy", 32'(load_busy), 32'd0);
                chk("abort_done", 32'(load_done), 32'd0);
                break;
            end
            if (n < N_PIX) chk("early_done", 32'(load_done), 32'd0);
        end

        if (aborted) begin
            tick();
            chk("abort_done2",  32'(load_done),   32'd0);
            chk("abort_loaded", 32'(slot_loaded), 32'(exp_loaded));
            chk("abort_idle",   32'(src_ready),   32'd0);
            $display("load slot %0d aborted after %0d transfers, slot_loaded %b", slot, n, slot_loaded);
            return;
        end

        chk("transfer_count", 32'(n), 32'(N_PIX));
        // Now in DONE: start_load and abort must be ignored here.
        chk("done_pulse", 32'(load_done), 32'd1);
        chk("done_busy",  32'(load_busy), 32'd0);
        chk("done_ready", 32'(src_ready), 32'd0);
        slot_release = rel_done;
        start_load   = 1'b1;
        slot_sel     = slot;
        abort        = 1'b1;
        tick();
        clear_inputs();
        exp_loaded = (exp_loaded & ~rel_done) | (4'b0001 << slot);
        chk("done_loaded",   32'(slot_loaded), 32'(exp_loaded));
        chk("done_cleared",  32'(load_done),   32'd0);
        chk("done_no_err",   32'(load_err),    32'd0);
        chk("done_to_idle",  32'(load_busy),   32'd0);
        chk("done_cb_hold",  32'(CB_select),   32'(exp_cb));
        $display("load slot %0d mode %0d complete: %0d transfers in %0d cycles, slot_loaded %b",
                 slot, mode, n, cycles, slot_loaded);
    endtask

    initial begin
        logic [1:0] rs;

        clear_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Sequential pixels 1..64 into slot 2
        run_load(2'd2, 0, -1, -1, 4'd0);
        chk("slot2_loaded", 32'(slot_loaded), 32'h4);

        // Rejections: slot already loaded, slot under comparison
        try_reject(2'd2, 1'b0, 2'd0);
        try_reject(2'd1, 1'b1, 2'd1);

        // Alternating valid into slot 1
        run_load(2'd1, 1, -1, -1, 4'd0);

        // Abort after 10 transfers, then reload the same slot
        run_load(2'd0, 2, 10, -1, 4'd0);
        run_load(2'd0, 2, -1, -1, 4'd0);

        // Release of slot 3 coinciding with DONE of slot 3
        run_load(2'd3, 2, -1, -1, 4'b1000);
        chk("slot3_set_wins", 32'(slot_loaded[3]), 32'd1);

        do_release(4'b0110);

        // Random loads into random slots
        for (int i = 0; i < 6; i++) begin
            rs = 2'($urandom);
            if (exp_loaded[rs]) do_release((4'b0001 << rs) | 4'($urandom));
            run_load(rs, 2, -1, -1, 4'd0);
        end

        // Reset in the middle of a load, then a clean load afterwards
        if (exp_loaded[2]) do_release(4'b0100);
        run_load(2'd2, 0, -1, 30, 4'd0);
        repeat (3) begin
            tick();
            chk("post_rst_no_done", 32'(load_done), 32'd0);
            chk("post_rst_idle",    32'(load_busy), 32'd0);
        end
        run_load(2'd2, 2, -1, -1, 4'd0);
        chk("post_rst_loaded", 32'(slot_loaded), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/curr_cb_feeder.md
CURR_CB_FEEDER -- requirements
Module: curr_cb_feeder

Interface
REQ-001 The block SHALL have parameter N_PIX, default 64, meaning the number of pixels pushed per current-block load (PE chain depth); legal range 2..256.
REQ-002 The block SHALL have parameter PIXEL_W, default 8, meaning the pixel width in bits.
REQ-003 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_load  input  1  request to load one block into slot slot_sel.
REQ-006 slot_sel  input  2  target CB slot, 0..3.
REQ-007 abort  input  1  cancel the load in progress.
REQ-008 src_pix  input  PIXEL_W  source pixel.
REQ-009 src_valid  input  1  src_pix valid.
REQ-010 src_ready  output  1  feeder accepts src_pix this cycle.
REQ-011 cmp_active  input  1  the PE array is currently differencing slot cmp_slot.
REQ-012 cmp_slot  input  2  slot in use by the comparison (abs_Control[1:0]).
REQ-013 slot_release  input  4  one-hot per slot; clears the slot_loaded bit.
REQ-014 in_curr  output  PIXEL_W  pixel to the first PE.
REQ-015 in_curr_enable  output  1  shift-enable to the PE chain.
REQ-016 CB_select  output  3  PE register slot select.
REQ-017 slot_loaded  output  4  per-slot "block fully loaded" status.
REQ-018 load_busy  output  1  high while in LOAD.
REQ-019 load_done  output  1  one-cycle pulse when a load completes.
REQ-020 load_err  output  1  one-cycle pulse when start_load is rejected.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-022 In IDLE, start_load=1 SHALL be rejected (load_err=1 next cycle, state stays IDLE) when slot_loaded[slot_sel]=1, or when cmp_active=1 and cmp_slot=slot_sel.
REQ-023 Otherwise, in IDLE, start_load=1 SHALL capture slot_sel into an internal slot register, clear the pixel counter, and enter LOAD next cycle.
REQ-024 CB_select SHALL equal {1'b0, captured slot} from the cycle after start_load is accepted and SHALL hold that value through LOAD, DONE and the following IDLE until the next accepted start_load.
REQ-025 src_ready SHALL be 1 only in LOAD (combinational from state); in IDLE and DONE it SHALL be 0.
REQ-026 On a transfer cycle (src_valid & src_ready), in_curr SHALL take src_pix and in_curr_enable SHALL be 1 on the following cycle (latency 1); on every other cycle in_curr_enable SHALL be 0 and in_curr SHALL hold its value.
REQ-027 The pixel counter SHALL be ceil(log2(N_PIX)) bits wide and increment once per transfer.
REQ-028 The transfer at counter value N_PIX-1 SHALL move LOAD to DONE; exactly N_PIX transfers SHALL occur per load.
REQ-029 src_valid=0 in LOAD SHALL stall the load with no timeout: counter held, in_curr_enable=0.
REQ-030 DONE SHALL last one cycle: load_done=1, slot_loaded[slot] set, then IDLE.
REQ-031 start_load while in LOAD or DONE SHALL be ignored without asserting load_err.
REQ-032 abort=1 in LOAD SHALL return the FSM to IDLE next cycle and leave slot_loaded unchanged.
REQ-033 A transfer in the abort cycle SHALL still be pushed.
REQ-034 abort in IDLE or DONE SHALL have no effect.
REQ-035 slot_release[i]=1 SHALL clear slot_loaded[i] next cycle.
REQ-036 If release and DONE target the same slot in the same cycle, the set SHALL win.
REQ-037 cmp_active changes during LOAD SHALL not affect an accepted load.
REQ-038 No pixel arithmetic SHALL be performed; in_curr is a bit-exact copy of src_pix.

Reset
REQ-039 While rst_n=0, the block SHALL hold state=IDLE, counter=0, slot register=0, in_curr=0, in_curr_enable=0, CB_select=0, slot_loaded=0, load_done=0 and load_err=0; src_ready and load_busy are then 0.
REQ-040 Reset asserted mid-LOAD SHALL abandon the load immediately; no load_done SHALL follow.

Verification
REQ-041 The bench SHALL cover: start_load slot 2, src_valid held 1 with pixels 1..64 -> CB_select=3'b010, in_curr 1..64 on consecutive cycles with in_curr_enable=1, then load_done one cycle after pixel 64 is accepted, slot_loaded=4'b0100.
REQ-042 The bench SHALL cover: src_valid toggling 1,0 during a load -> 64 enable pulses only on the cycles following transfers; the counter never exceeds 63.
REQ-043 The bench SHALL cover: start_load slot 2 while slot_loaded[2]=1, and start_load slot 1 with cmp_active=1 and cmp_slot=1 -> load_err pulses, src_ready stays 0.
REQ-044 The bench SHALL cover: abort after 10 transfers -> IDLE, slot_loaded unchanged, no load_done; a reload of the same slot succeeds.
REQ-045 The bench SHALL cover: slot_release[3] in the same cycle as DONE for slot 3 -> slot_loaded[3]=1.
REQ-046 The bench SHALL cover: rst_n low after 30 transfers -> all outputs 0 asynchronously; a new load after reset completes normally.
